address_for_mem: RTL and testbench
==================================

// Module: address_for_mem
// PURPOSE
//  MEM-stage load/store glue for the MIPS datapath. Store side: forms the 12-bit word address,
//  per-byte write enables for the imem and dmem ports, and the lane-shifted store data.
//  Load side (sub-module load_logic): extracts and extends the addressed byte/half from the
//  returned word. Both paths are combinational.
//  A small registered stage carries the load byte offset and control to the WB stage.
// PARAMETERS
//  ADR_W   12  width of mem_adr; word address = alu_out[ADR_W+1:2]
// PORTS
//  Clock        in   1   system clock (rising edge)
//  Reset        in   1   asynchronous, active-high reset
//  RTin         in   32  store data (rt register value)
//  alu_out      in   32  effective byte address
//  LdStCtrl     in   3   op: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
//  mem_adr      out  12  word address to memories
//  we_i         out  4   imem byte write enables; bit3 = bits[31:24]
//  we_d         out  4   dmem byte write enables; same lane order
//  RTout        out  32  store data shifted onto the addressed lanes
//  ld_word      in   32  word read from memory (load_logic.word)
//  byte_sel     in   2   byte offset of the load (address[1:0])
//  word_out     out  32  aligned, extended load result
//  ld_sel_q     out  2   alu_out[1:0] registered
//  ld_ctrl_q    out  3   LdStCtrl registered
// BEHAVIOUR
//  Byte ordering is big-endian. Offset b selects bits [31-8b -: 8]. Half h = b[1] selects
//  bits [31-16h -: 16].
//  mem_adr = alu_out[13:2]. It is driven for every op.
//  mask: SB = 4'b1000 >> off. SH = off[1] ? 4'b0011 : 4'b1100, with off[0] ignored.
//    SW = 4'b1111. Loads = 4'b0000.
//  RTout:
//    SB: RTin << 8*(3-off)
//    SH: RTin << (off[1] ? 0 : 16)
//    SW and loads: RTin unchanged
//  Upper bits shifted out are dropped. Low bits fill with 0.
//  Memory map:
//    we_d = mask when alu_out[31]==0 && alu_out[28]==1, else 0
//    we_i = mask when alu_out[31]==0 && alu_out[29]==1, else 0
//    Both may be active at once, e.g. region 0x7xxxxxxx.
//  word_out, by LdStCtrl:
//    LB / LBU: selected byte, sign- / zero-extended
//    LH / LHU: selected half, sign- / zero-extended
//    LW and store codes: ld_word unchanged
//  Misaligned LH/LHU/SH use b[1] only. No exception is raised.
//  ld_sel_q / ld_ctrl_q:
//    Load from alu_out[1:0] / LdStCtrl on each rising Clock edge.
//    Reset clears them to 0 asynchronously. Reset taken mid-operation forces 0 immediately.
//  All other outputs are purely combinational and are unaffected by Clock and Reset.
//  Latency 0.
// STRUCTURE
//  Shared package: LdStCtrl encodings (LD_LB..ST_SW), region bit indices (DMEM_BIT=28,
//  IMEM_BIT=29, IO_BIT=31).
//  One sub-module, load_logic (word, LdStCtrl, byte_sel -> word_out). Top contains the store
//  path and the 5-bit register.
// TESTING
//  SB: alu_out=0x70000005, RTin=0xdeadbeef, ctrl=101 -> mem_adr=0x001, we_i=we_d=0100,
//    RTout=0xbeef0000.
//  SH: same address and data, ctrl=110 -> we_i=we_d=1100, RTout=0xbeef0000.
//    With alu_out=0x10000002 -> we_d=0011, we_i=0000, RTout=0xdeadbeef.
//  LB: word=0xdeadbeef, sel=10 -> 0xffffffbe. word=0x5eadbeef, sel=00 -> 0x0000005e.
//    LBU sel=10 -> 0x000000be.
//  LH: sel=10 -> 0xffffbeef. LHU: sel=01 -> 0x0000dead. LW: sel=10 -> 0xdeadbeef.
//  SW to 0x80000000 -> we_i=we_d=0000. Any load op -> both enables 0000.
//  Reg: assert Reset mid-cycle -> ld_sel_q/ld_ctrl_q=0 at once.
//    Release Reset, clock with alu_out=0x..3, ctrl=011 -> 2'b11 / 3'b011.

Source files
------------

// File: rtl/address_for_mem_pkg.sv
// address_for_mem_pkg: load/store op encodings and memory-region address bits
package address_for_mem_pkg;
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100,
    ST_SB  = 3'b101,
    ST_SH  = 3'b110,
    ST_SW  = 3'b111
  } ld_st_e;
  localparam int DMEM_BIT = 28;
  localparam int IMEM_BIT = 29;
  localparam int IO_BIT   = 31;
endpackage

// File: rtl/address_for_mem_load_logic.sv
// load_logic: big-endian byte/half extraction and extension of a loaded word (word, LdStCtrl, byte_sel -> word_out)
module load_logic
  import address_for_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  LdStCtrl,
  input  logic [1:0]  byte_sel,
  output logic [31:0] word_out
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sh = word << {byte_sel, 3'b000};
    b  = sh[31:24];
    h  = byte_sel[1] ? word[15:0] : word[31:16];
    word_out = (LdStCtrl == LD_LB)  ? {{24{b[7]}}, b} :
               (LdStCtrl == LD_LBU) ? {24'd0, b} :
               (LdStCtrl == LD_LH)  ? {{16{h[15]}}, h} :
               (LdStCtrl == LD_LHU) ? {16'd0, h} : word;
  end
endmodule

// File: rtl/address_for_mem.sv
// address_for_mem: MEM-stage store address/enable/data shaping, load extraction, and WB pipeline register
module address_for_mem
  import address_for_mem_pkg::*;
#(
  parameter int ADR_W = 12
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      RTin,
  input  logic [31:0]      alu_out,
  input  logic [2:0]       LdStCtrl,
  output logic [ADR_W-1:0] mem_adr,
  output logic [3:0]       we_i,
  output logic [3:0]       we_d,
  output logic [31:0]      RTout,
  input  logic [31:0]      ld_word,
  input  logic [1:0]       byte_sel,
  output logic [31:0]      word_out,
  output logic [1:0]       ld_sel_q,
  output logic [2:0]       ld_ctrl_q
);
  logic [1:0]  off;
  logic [3:0]  mask;
  logic        d_hit;
  logic        i_hit;
  always_comb begin
    off     = alu_out[1:0];
    mem_adr = alu_out[ADR_W+1:2];
    mask    = (LdStCtrl == ST_SB) ? 4'b1000 >> off :
              (LdStCtrl == ST_SH) ? (off[1] ? 4'b0011 : 4'b1100) :
              (LdStCtrl == ST_SW) ? 4'b1111 : 4'b0000;
    RTout   = (LdStCtrl == ST_SB) ? RTin << {~off, 3'b000} :
              (LdStCtrl == ST_SH) ? (off[1] ? RTin : RTin << 16) : RTin;
    d_hit   = !alu_out[IO_BIT] && alu_out[DMEM_BIT];
    i_hit   = !alu_out[IO_BIT] && alu_out[IMEM_BIT];
    we_d    = d_hit ? mask : 4'b0000;
    we_i    = i_hit ? mask : 4'b0000;
  end
  load_logic u_load (
    .word     (ld_word),
    .LdStCtrl (LdStCtrl),
    .byte_sel (byte_sel),
    .word_out (word_out)
  );
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ld_sel_q  <= '0;
      ld_ctrl_q <= '0;
    end else begin
      ld_sel_q  <= alu_out[1:0];
      ld_ctrl_q <= LdStCtrl;
    end
  end
endmodule

// File: tb/tb_address_for_mem.sv
// tb_address_for_mem: table-driven directed checks of store/load paths plus reset/register sequences
module tb_address_for_mem;
  logic        Clock = 0;
  logic        Reset = 1;
  logic [31:0] RTin = 0;
  logic [31:0] alu_out = 0;
  logic [2:0]  LdStCtrl = 0;
  logic [11:0] mem_adr;
  logic [3:0]  we_i, we_d;
  logic [31:0] RTout;
  logic [31:0] ld_word = 0;
  logic [1:0]  byte_sel = 0;
  logic [31:0] word_out;
  logic [1:0]  ld_sel_q;
  logic [2:0]  ld_ctrl_q;
  int n_vec = 0;
  int n_err = 0;

  address_for_mem dut (
    .Clock(Clock), .Reset(Reset), .RTin(RTin), .alu_out(alu_out), .LdStCtrl(LdStCtrl),
    .mem_adr(mem_adr), .we_i(we_i), .we_d(we_d), .RTout(RTout), .ld_word(ld_word),
    .byte_sel(byte_sel), .word_out(word_out), .ld_sel_q(ld_sel_q), .ld_ctrl_q(ld_ctrl_q)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] rtin;
    logic [31:0] alu;
    logic [2:0]  ctrl;
    logic [31:0] word;
    logic [1:0]  sel;
    logic [11:0] e_adr;
    logic [3:0]  e_wi;
    logic [3:0]  e_wd;
    logic [31:0] e_rt;
    logic [31:0] e_wo;
  } vec_t;

  vec_t v[17];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  initial begin
    v[0]  = '{32'hdeadbeef, 32'h70000005, 3'b101, 32'hdeadbeef, 2'b10, 12'h001, 4'b0100, 4'b0100, 32'hbeef0000, 32'hdeadbeef};
    v[1]  = '{32'hdeadbeef, 32'h70000005, 3'b110, 32'hdeadbeef, 2'b10, 12'h001, 4'b1100, 4'b1100, 32'hbeef0000, 32'hdeadbeef};
    v[2]  = '{32'hdeadbeef, 32'h10000002, 3'b110, 32'hdeadbeef, 2'b10, 12'h000, 4'b0000, 4'b0011, 32'hdeadbeef, 32'hdeadbeef};
    v[3]  = '{32'hdeadbeef, 32'h10000002, 3'b000, 32'hdeadbeef, 2'b10, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'hffffffbe};
    v[4]  = '{32'hdeadbeef, 32'h70000000, 3'b000, 32'h5eadbeef, 2'b00, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'h0000005e};
    v[5]  = '{32'hdeadbeef, 32'h70000000, 3'b011, 32'hdeadbeef, 2'b10, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'h000000be};
    v[6]  = '{32'hdeadbeef, 32'h70000000, 3'b001, 32'hdeadbeef, 2'b10, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'hffffbeef};
    v[7]  = '{32'hdeadbeef, 32'h70000000, 3'b100, 32'hdeadbeef, 2'b01, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'h0000dead};
    v[8]  = '{32'hdeadbeef, 32'h70000000, 3'b010, 32'hdeadbeef, 2'b10, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'hdeadbeef};
    v[9]  = '{32'hdeadbeef, 32'h80000000, 3'b111, 32'h12345678, 2'b00, 12'h000, 4'b0000, 4'b0000, 32'hdeadbeef, 32'h12345678};
    v[10] = '{32'hdeadbeef, 32'h20000ffc, 3'b111, 32'h12345678, 2'b00, 12'h3ff, 4'b1111, 4'b0000, 32'hdeadbeef, 32'h12345678};
    v[11] = '{32'h000000a5, 32'h10000003, 3'b101, 32'h00000000, 2'b11, 12'h000, 4'b0000, 4'b0001, 32'h000000a5, 32'h00000000};
    v[12] = '{32'h12345678, 32'h30000000, 3'b101, 32'h00000000, 2'b00, 12'h000, 4'b1000, 4'b1000, 32'h78000000, 32'h00000000};
    v[13] = '{32'h12345678, 32'h30000000, 3'b001, 32'h1234f678, 2'b11, 12'h000, 4'b0000, 4'b0000, 32'h12345678, 32'hfffff678};
    v[14] = '{32'h12345678, 32'h30000000, 3'b000, 32'h12805678, 2'b01, 12'h000, 4'b0000, 4'b0000, 32'h12345678, 32'hffffff80};
    v[15] = '{32'h12345678, 32'h0000fffc, 3'b010, 32'h00000000, 2'b00, 12'hfff, 4'b0000, 4'b0000, 32'h12345678, 32'h00000000};
    v[16] = '{32'h0000cafe, 32'h10000003, 3'b110, 32'h00000000, 2'b00, 12'h000, 4'b0000, 4'b0011, 32'h0000cafe, 32'h00000000};
    #3;
    chk("rst_sel", {30'd0, ld_sel_q}, 32'd0);
    chk("rst_ctrl", {29'd0, ld_ctrl_q}, 32'd0);
    @(negedge Clock);
    Reset = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge Clock);
      RTin = v[i].rtin; alu_out = v[i].alu; LdStCtrl = v[i].ctrl;
      ld_word = v[i].word; byte_sel = v[i].sel;
      #1;
      chk($sformatf("v%0d_adr", i), {20'd0, mem_adr}, {20'd0, v[i].e_adr});
      chk($sformatf("v%0d_we_i", i), {28'd0, we_i}, {28'd0, v[i].e_wi});
      chk($sformatf("v%0d_we_d", i), {28'd0, we_d}, {28'd0, v[i].e_wd});
      chk($sformatf("v%0d_rtout", i), RTout, v[i].e_rt);
      chk($sformatf("v%0d_word_out", i), word_out, v[i].e_wo);
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_sel_q", i), {30'd0, ld_sel_q}, {30'd0, v[i].alu[1:0]});
      chk($sformatf("v%0d_ctrl_q", i), {29'd0, ld_ctrl_q}, {29'd0, v[i].ctrl});
    end
    @(negedge Clock);
    alu_out = 32'h10000003; LdStCtrl = 3'b011;
    @(posedge Clock); #1;
    chk("reg_sel_11", {30'd0, ld_sel_q}, 32'd3);
    chk("reg_ctrl_011", {29'd0, ld_ctrl_q}, 32'd3);
    @(negedge Clock);
    alu_out = 32'h10000002; LdStCtrl = 3'b110;
    #2;
    chk("hold_sel", {30'd0, ld_sel_q}, 32'd3);
    Reset = 1;
    #1;
    chk("async_rst_sel", {30'd0, ld_sel_q}, 32'd0);
    chk("async_rst_ctrl", {29'd0, ld_ctrl_q}, 32'd0);
    chk("rst_comb_we_d", {28'd0, we_d}, 32'h3);
    @(posedge Clock); #1;
    chk("rst_hold_ctrl", {29'd0, ld_ctrl_q}, 32'd0);
    @(negedge Clock);
    Reset = 0;
    alu_out = 32'h70000003; LdStCtrl = 3'b011;
    @(posedge Clock); #1;
    chk("rel_sel", {30'd0, ld_sel_q}, 32'd3);
    chk("rel_ctrl", {29'd0, ld_ctrl_q}, 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
